rf_dispatch_sched: RTL
======================

Name: rf_dispatch_sched

Overview:
- Issue-side scheduler for the register file's rename/issue port.
- Allocates ROB tags (the Qn value written into the register file's q[rd]) in circular order, tracks in-flight occupancy and throttles decoder issue when no tag is free.
- Retires tags in order on commit and recovers on misprediction.
- Sits between the decoder/issue stage and the register file/ROB.

Parameters:
- ROB_ADD_W, 4, tag width; tag 0 is reserved as "no dependency", so valid tags are 1..2^ROB_ADD_W-1 and capacity CAP = 2^ROB_ADD_W-1.
- FLUSH_CYC, 2, number of cycles issue is blocked after a misprediction (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  global enable; when low, state is frozen
- iIS_Req  in  1  decoder has an instruction to issue
- oIS_Rdy  out  1  scheduler can accept an issue this cycle (registered-state derived)
- oRF_En  out  1  issue strobe to the register file; combinational = iIS_Req & oIS_Rdy & ~iMp & en
- oRF_Qn  out  ROB_ADD_W  tag for the issuing instruction (current tail)
- iCM_En  in  1  ROB commit valid
- iCM_Tag  in  ROB_ADD_W  tag being committed
- iMp  in  1  misprediction flush
- oCount  out  ROB_ADD_W  in-flight tag count, 0..CAP
- oFull  out  1  oCount == CAP
- oEmpty  out  1  oCount == 0
- oFlushing  out  1  state == FLUSH
- oCmErr  out  1  sticky: out-of-order commit, or commit while empty

Behaviour:
- Reset values: head=1, tail=1, count=0, state RUN, flush counter 0, oCmErr=0.
  - Outputs after reset: oIS_Rdy=1, oRF_En=0, oRF_Qn=1, oCount=0, oFull=0, oEmpty=1, oFlushing=0.
  - rst has priority over every other input.
- States:
  - RUN: oIS_Rdy = ~full. Transitions to FLUSH on iMp.
  - FLUSH: oIS_Rdy=0. Flush counter counts FLUSH_CYC-1 down to 0, then returns to RUN.
  - A new iMp while in FLUSH reloads the counter.
- Issue (oRF_En=1):
  - oRF_Qn = tail this cycle.
  - Next cycle: tail advances to the next tag, wrapping 2^W-1 -> 1 and skipping 0; count increments.
  - Zero latency: the tag is valid in the same cycle as the strobe.
- Commit (iCM_En, state RUN):
  - If count>0 and iCM_Tag==head: head advances with the same wrap rule and count decrements.
  - Otherwise the commit is ignored and oCmErr is set.
- Simultaneous issue and commit in the same cycle: count is unchanged, both head and tail advance.
- Full: the full check uses the pre-cycle count, so a commit arriving in the same cycle does not unblock issue until the next cycle.
- Misprediction (iMp=1):
  - Next cycle: head=tail=1, count=0, state FLUSH.
  - oRF_En is forced 0 in the iMp cycle.
  - A commit in the iMp cycle is discarded.
  - Commits during FLUSH are ignored and do not set oCmErr.
  - Rationale: the register file clears all q in the same cycle as the misprediction, so tag 1 is immediately safe to reuse.
- en=0: oRF_En=0 and oIS_Rdy=0. Commits and iMp are ignored. All state holds.
- oCount, oFull, oEmpty, oFlushing: driven from registered state.

Optional Feature:
- Macro: RF_DISPATCH_STAT_EN.
- Enabled: adds 32-bit outputs oStatIssue (issues), oStatStall (cycles with iIS_Req=1, oIS_Rdy=0, en=1) and oStatFlush (iMp events).
  - All three are cleared only by rst, wrap at 2^32 and are frozen when en=0.
- Disabled: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then iIS_Req=1 for 3 cycles, no commits -> oRF_Qn=1,2,3 with oRF_En=1 each cycle; oCount=3.
- Issue 15 back-to-back with W=4, no commits -> oFull=1 and oIS_Rdy=0 on the 16th cycle; tags 1..15; no tag 0 ever issued.
- Full, then commit tag 1 with iIS_Req held -> no issue in the commit cycle; next cycle oRF_Qn=1 (wrap), oCount=15.
- 5 in flight (head=1), commit tag 3 -> ignored, oCmErr=1 sticky, oCount=5; then commit 1 -> oCount=4, head=2.
- 4 in flight, iMp with iIS_Req and iCM_En both high -> oRF_En=0 that cycle; then oFlushing=1 for 2 cycles with oCount=0; first new issue gets oRF_Qn=1.
- Issue and commit in the same cycle with count=7 -> oCount stays 7; en=0 for 3 cycles with iIS_Req=1 -> no oRF_En and no state change.

Source files
------------

// File: rtl/rf_dispatch_sched.sv
// ROB tag allocator / issue throttle between decoder and register file.
// Optional event counters are built when RF_DISPATCH_STAT_EN is defined.
module rf_dispatch_sched #(
    parameter int unsigned ROB_ADD_W = 4,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iIS_Req,
    output logic                 oIS_Rdy,
    output logic                 oRF_En,
    output logic [ROB_ADD_W-1:0] oRF_Qn,
    input  logic                 iCM_En,
    input  logic [ROB_ADD_W-1:0] iCM_Tag,
    input  logic                 iMp,
    output logic [ROB_ADD_W-1:0] oCount,
    output logic                 oFull,
    output logic                 oEmpty,
    output logic                 oFlushing,
    output logic                 oCmErr
`ifdef RF_DISPATCH_STAT_EN
    ,
    output logic [31:0]          oStatIssue,
    output logic [31:0]          oStatStall,
    output logic [31:0]          oStatFlush
`endif
);

    localparam logic [ROB_ADD_W-1:0] CAP        = '1;
    localparam logic [ROB_ADD_W-1:0] TAG_ONE    = ROB_ADD_W'(1);
    localparam logic [3:0]           FLUSH_LOAD = 4'(FLUSH_CYC - 1);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e                 state_q, state_d;
    logic [ROB_ADD_W-1:0]   head_q, head_d;
    logic [ROB_ADD_W-1:0]   tail_q, tail_d;
    logic [ROB_ADD_W-1:0]   count_q, count_d;
    logic [3:0]             flush_cnt_q, flush_cnt_d;
    logic                   cm_err_q, cm_err_d;
    logic                   running;
    logic                   full;
    logic                   cm_valid;
    logic                   cm_ok;

    // Tag 0 means "no dependency", so the ring runs 1..CAP.
    function automatic logic [ROB_ADD_W-1:0] next_tag(input logic [ROB_ADD_W-1:0] t);
        return (t == CAP) ? TAG_ONE : t + TAG_ONE;
    endfunction

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        flush_cnt_d = flush_cnt_q;
        cm_err_d    = cm_err_q;

        running  = (state_q == StRun);
        full     = (count_q == CAP);
        oIS_Rdy  = en & running & ~full;
        oRF_En   = iIS_Req & oIS_Rdy & ~iMp & en;
        cm_valid = en & iCM_En & running & ~iMp;
        cm_ok    = cm_valid & (count_q != '0) & (iCM_Tag == head_q);

        if (en) begin
            if (iMp) begin
                // RF clears every q[] this cycle, so tag 1 is reusable at once.
                head_d      = TAG_ONE;
                tail_d      = TAG_ONE;
                count_d     = '0;
                state_d     = StFlush;
                flush_cnt_d = FLUSH_LOAD;
            end else begin
                if (cm_valid && !cm_ok) cm_err_d = 1'b1;
                if (cm_ok)  head_d = next_tag(head_q);
                if (oRF_En) tail_d = next_tag(tail_q);
                case ({oRF_En, cm_ok})
                    2'b10:   count_d = count_q + TAG_ONE;
                    2'b01:   count_d = count_q - TAG_ONE;
                    default: count_d = count_q;
                endcase
                if (!running) begin
                    if (flush_cnt_q == 4'd0) state_d = StRun;
                    else flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            head_q      <= TAG_ONE;
            tail_q      <= TAG_ONE;
            count_q     <= '0;
            flush_cnt_q <= 4'd0;
            cm_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            flush_cnt_q <= flush_cnt_d;
            cm_err_q    <= cm_err_d;
        end
    end

    assign oRF_Qn    = tail_q;
    assign oCount    = count_q;
    assign oFull     = full;
    assign oEmpty    = (count_q == '0);
    assign oFlushing = (state_q == StFlush);
    assign oCmErr    = cm_err_q;

`ifdef RF_DISPATCH_STAT_EN
    logic [31:0] stat_issue_q, stat_stall_q, stat_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issue_q <= '0;
            stat_stall_q <= '0;
            stat_flush_q <= '0;
        end else if (en) begin
            if (oRF_En)             stat_issue_q <= stat_issue_q + 32'd1;
            if (iIS_Req && !oIS_Rdy) stat_stall_q <= stat_stall_q + 32'd1;
            if (iMp)                stat_flush_q <= stat_flush_q + 32'd1;
        end
    end

    assign oStatIssue = stat_issue_q;
    assign oStatStall = stat_stall_q;
    assign oStatFlush = stat_flush_q;
`endif

endmodule
